instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential MIPS instruction encoder: the encode-side counterpart of the control decoder. It accepts one mnemonic plus operand fields per valid/ready handshake, assembles the 32-bit machine word using the same opcode/funct encodings the decoder recognises, and writes it into instruction memory at consecutive word addresses. It sits between a testbench or host program source and the imem write port, and builds runnable programs terminated by the exit syscall sequence.

## Interface
- ADDR_W, 10, imem word-address width; capacity 2^ADDR_W words
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  encoder can accept; combinational = (state==IDLE) & !full & !done
- op  in  5  mnemonic: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 JR, 6 SYSCALL, 7 ADDI, 8 ADDIU, 9 SLTIU, 10 ORI, 11 LUI, 12 LW, 13 SW, 14 BEQ, 15 BNE, 16 J, 17 JAL, 18 EXIT; 19–31 illegal
- rs, rt, rd  in  5 each  register fields
- imm  in  16  immediate / branch offset
- target  in  26  jump target field
- wr_en  out  1  imem write strobe, one cycle per word
- wr_addr  out  ADDR_W  imem word address
- wr_data  out  32  encoded word
- count  out  ADDR_W+1  words written since reset
- full  out  1  count == 2^ADDR_W
- err  out  1  sticky: illegal op or dropped EXIT word
- done  out  1  sticky: EXIT sequence completed

## Operation
- R-type {6'b000000, rs, rt, rd, 5'b0, funct}; funct ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
- JR {6'b0, rs, 15'b0, 6'b001000}; SYSCALL 32'h0000000C (operands ignored).
- I-type {opcode, rs, rt, imm}; opcodes ADDI 001000, ADDIU 001001, SLTIU 001011, ORI 001101, LW 100011, SW 101011, BEQ 000100, BNE 000101. LUI 001111 forces rs=0.
- J-type {opcode, target}; J 000010, JAL 000011.
- EXIT emits two words: 32'h2402000A (ADDIU $2,$0,10), then 32'h0000000C.
- FSM: IDLE, EXIT2. IDLE + accepted EXIT -> EXIT2; EXIT2 -> IDLE unconditionally next cycle, writes second word, sets done.
- Write pointer = count[ADDR_W-1:0]; increments by 1 per written word; never wraps — full blocks further acceptance.
- Illegal op: accepted (handshake completes), no write, count unchanged, err set.
- EXIT accepted with exactly one free slot: first word written, full asserts, second word dropped, err set, done not set.
- After done: in_ready held low until reset.

## Timing
- Accept = in_valid & in_ready at rising edge k. wr_en, wr_addr, wr_data, count are registered and update at edge k; wr_en is high for the cycle after k only.
- Single-word latency: 1 cycle accept-to-write. Back-to-back accepts every cycle sustain one write per cycle.
- EXIT: word 1 at edge k, in_ready low during cycle after k, word 2 at edge k+1, done high after edge k+1.
- full/err/done are registered, visible the cycle after the causing edge.
- Reset values: wr_en 0, wr_addr 0, wr_data 0, count 0, full 0, err 0, done 0, state IDLE, so in_ready is 1 once reset deasserts.
- Reset asserted in EXIT2: second word not written, all state cleared immediately.
- in_valid low: no state change; held operands ignored.

## Test plan
- ADD rs=1 rt=2 rd=3, then ADDI rs=0 rt=8 imm=16'h0005 -> wr_data 32'h00221820 @ addr 0, 32'h20080005 @ addr 1; count=2.
- LW rt=9 rs=29 imm=4, BEQ rs=8 rt=9 imm=16'hFFFF, J target=26'h0000010 -> 32'h8FA90004, 32'h1109FFFF, 32'h08000010 on consecutive cycles, addrs 0,1,2.
- EXIT after two instructions -> 32'h2402000A @2, in_ready low one cycle, 32'h0000000C @3, done=1, in_ready stays 0.
- op=25 with in_valid -> handshake completes, wr_en stays 0, count unchanged, err=1 next cycle; following SYSCALL still written at same address.
- ADDR_W=2: three ORs then EXIT -> word 1 of EXIT at addr 3, full=1, err=1, done=0, in_ready 0.
- Reset asserted during EXIT2 -> no second write, all outputs at reset values, next ADD written at addr 0.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder
//   Sequential MIPS instruction encoder. Accepts one mnemonic plus operand
//   fields per valid/ready handshake and writes the assembled 32-bit word
//   into instruction memory at consecutive word addresses. EXIT expands to
//   the two-word exit syscall sequence (ADDIU $2,$0,10 ; SYSCALL).
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   request handshake
//   op                    mnemonic code (0..18 legal, 19..31 illegal)
//   rs, rt, rd            register fields
//   imm                   immediate / branch offset
//   target                jump target field
//   wr_en                 imem write strobe, one cycle per word
//   wr_addr, wr_data      imem word address and encoded word
//   count                 words written since reset
//   full                  imem completely written
//   err                   sticky: illegal op or dropped EXIT word
//   done                  sticky: EXIT sequence completed
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a request (unless full or done)
// EXIT2 | first EXIT word written; second word (SYSCALL) written now

module instr_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic              done
);

  localparam logic [4:0] OP_ADD     = 5'd0;
  localparam logic [4:0] OP_SUB     = 5'd1;
  localparam logic [4:0] OP_AND     = 5'd2;
  localparam logic [4:0] OP_OR      = 5'd3;
  localparam logic [4:0] OP_SLT     = 5'd4;
  localparam logic [4:0] OP_JR      = 5'd5;
  localparam logic [4:0] OP_SYSCALL = 5'd6;
  localparam logic [4:0] OP_ADDI    = 5'd7;
  localparam logic [4:0] OP_ADDIU   = 5'd8;
  localparam logic [4:0] OP_SLTIU   = 5'd9;
  localparam logic [4:0] OP_ORI     = 5'd10;
  localparam logic [4:0] OP_LUI     = 5'd11;
  localparam logic [4:0] OP_LW      = 5'd12;
  localparam logic [4:0] OP_SW      = 5'd13;
  localparam logic [4:0] OP_BEQ     = 5'd14;
  localparam logic [4:0] OP_BNE     = 5'd15;
  localparam logic [4:0] OP_J       = 5'd16;
  localparam logic [4:0] OP_JAL     = 5'd17;
  localparam logic [4:0] OP_EXIT    = 5'd18;

  localparam logic [31:0] WORD_EXIT1   = 32'h2402000A;
  localparam logic [31:0] WORD_SYSCALL = 32'h0000000C;

  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {IDLE, EXIT2} state_t;
  state_t state;

  logic        accept;
  logic        legal;
  logic        is_exit;
  logic [31:0] word;
  logic [ADDR_W:0] count_nx;

  assign in_ready = (state == IDLE) & ~full & ~done;
  assign accept   = in_valid & in_ready;
  assign count_nx = count + 1'b1;

  function automatic logic [31:0] rtype(input logic [5:0] funct);
    return {6'b000000, rs, rt, rd, 5'b00000, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc);
    return {opc, rs, rt, imm};
  endfunction

  always_comb begin
    word    = 32'h0;
    legal   = 1'b1;
    is_exit = 1'b0;
    case (op)
      OP_ADD:     word = rtype(6'b100000);
      OP_SUB:     word = rtype(6'b100010);
      OP_AND:     word = rtype(6'b100100);
      OP_OR:      word = rtype(6'b100101);
      OP_SLT:     word = rtype(6'b101010);
      OP_JR:      word = {6'b000000, rs, 15'b0, 6'b001000};
      OP_SYSCALL: word = WORD_SYSCALL;
      OP_ADDI:    word = itype(6'b001000);
      OP_ADDIU:   word = itype(6'b001001);
      OP_SLTIU:   word = itype(6'b001011);
      OP_ORI:     word = itype(6'b001101);
      OP_LUI:     word = {6'b001111, 5'b00000, rt, imm};
      OP_LW:      word = itype(6'b100011);
      OP_SW:      word = itype(6'b101011);
      OP_BEQ:     word = itype(6'b000100);
      OP_BNE:     word = itype(6'b000101);
      OP_J:       word = {6'b000010, target};
      OP_JAL:     word = {6'b000011, target};
      OP_EXIT: begin
        word    = WORD_EXIT1;
        is_exit = 1'b1;
      end
      default:    legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= 32'h0;
      count   <= '0;
      full    <= 1'b0;
      err     <= 1'b0;
      done    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!legal) begin
              err <= 1'b1;
            end else begin
              wr_en   <= 1'b1;
              wr_addr <= count[ADDR_W-1:0];
              wr_data <= word;
              count   <= count_nx;
              full    <= (count_nx == CAP);
              if (is_exit) state <= EXIT2;
            end
          end
        end
        EXIT2: begin
          state <= IDLE;
          // The first EXIT word may have taken the last slot; the SYSCALL
          // word then has nowhere to go and the program is not runnable.
          if (full) begin
            err <= 1'b1;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= count[ADDR_W-1:0];
            wr_data <= WORD_SYSCALL;
            count   <= count_nx;
            full    <= (count_nx == CAP);
            done    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default-size instance plus an
// ADDR_W=2 instance for the capacity corner.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_valid2;
  logic [4:0]  op, rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;

  logic        in_ready, wr_en, full, err, done;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [10:0] count;

  logic        in_ready2, wr_en2, full2, err2, done2;
  logic [1:0]  wr_addr2;
  logic [31:0] wr_data2;
  logic [2:0]  count2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .count(count),
    .full(full), .err(err), .done(done)
  );

  instr_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2), .count(count2),
    .full(full2), .err(err2), .done(done2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] o, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [15:0] i, input logic [25:0] g);
    op = o; rs = s; rt = t; rd = d; imm = i; target = g;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    drive(5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    do_reset();

    // reset state
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_addr", wr_addr, 10'd0);
    chk("rst_data", wr_data, 32'h0);
    chk("rst_count", count, 11'd0);
    chk("rst_flags", {full, err, done}, 3'b000);
    chk("rst_ready", in_ready, 1'b1);

    // ADD, ADDI, then EXIT
    drive(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    in_valid = 1'b1;
    @(negedge clk);
    chk("add_en", wr_en, 1'b1);
    chk("add_addr", wr_addr, 10'd0);
    chk("add_data", wr_data, 32'h00221820);
    drive(5'd7, 5'd0, 5'd8, 5'd0, 16'h0005, 26'h0);
    @(negedge clk);
    chk("addi_addr", wr_addr, 10'd1);
    chk("addi_data", wr_data, 32'h20080005);
    chk("addi_count", count, 11'd2);
    drive(5'd18, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("exit1_en", wr_en, 1'b1);
    chk("exit1_addr", wr_addr, 10'd2);
    chk("exit1_data", wr_data, 32'h2402000A);
    chk("exit1_ready", in_ready, 1'b0);
    chk("exit1_done", done, 1'b0);
    @(negedge clk);
    chk("exit2_en", wr_en, 1'b1);
    chk("exit2_addr", wr_addr, 10'd3);
    chk("exit2_data", wr_data, 32'h0000000C);
    chk("exit2_done", done, 1'b1);
    chk("exit2_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    drive(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    @(negedge clk);
    chk("after_done_en", wr_en, 1'b0);
    chk("after_done_count", count, 11'd4);
    chk("after_done_ready", in_ready, 1'b0);
    chk("after_done_err", err, 1'b0);
    in_valid = 1'b0;

    // LW, BEQ, J back-to-back, then illegal op, then SYSCALL
    do_reset();
    drive(5'd12, 5'd29, 5'd9, 5'd0, 16'h0004, 26'h0);
    in_valid = 1'b1;
    @(negedge clk);
    chk("lw_addr", wr_addr, 10'd0);
    chk("lw_data", wr_data, 32'h8FA90004);
    drive(5'd14, 5'd8, 5'd9, 5'd0, 16'hFFFF, 26'h0);
    @(negedge clk);
    chk("beq_addr", wr_addr, 10'd1);
    chk("beq_data", wr_data, 32'h1109FFFF);
    drive(5'd16, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010);
    @(negedge clk);
    chk("j_en", wr_en, 1'b1);
    chk("j_addr", wr_addr, 10'd2);
    chk("j_data", wr_data, 32'h08000010);
    drive(5'd25, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h0);
    chk("ill_ready", in_ready, 1'b1);
    @(negedge clk);
    chk("ill_en", wr_en, 1'b0);
    chk("ill_count", count, 11'd3);
    chk("ill_err", err, 1'b1);
    drive(5'd6, 5'd7, 5'd7, 5'd7, 16'hFFFF, 26'h0);
    @(negedge clk);
    chk("sys_en", wr_en, 1'b1);
    chk("sys_addr", wr_addr, 10'd3);
    chk("sys_data", wr_data, 32'h0000000C);
    in_valid = 1'b0;
    // operands held with in_valid low must not be written
    drive(5'd11, 5'd31, 5'd4, 5'd0, 16'hBEEF, 26'h0);
    @(negedge clk);
    chk("idle_en", wr_en, 1'b0);
    chk("idle_count", count, 11'd4);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("lui_data", wr_data, 32'h3C04BEEF);
    chk("lui_addr", wr_addr, 10'd4);

    // ADDR_W=2: three ORs then EXIT with one slot left
    do_reset();
    drive(5'd3, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    in_valid2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("or_data", wr_data2, 32'h00221825);
    chk("or_count", count2, 3'd3);
    chk("or_full", full2, 1'b0);
    drive(5'd18, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    @(negedge clk);
    in_valid2 = 1'b0;
    chk("sm_exit1_addr", wr_addr2, 2'd3);
    chk("sm_exit1_data", wr_data2, 32'h2402000A);
    chk("sm_full", full2, 1'b1);
    @(negedge clk);
    chk("sm_exit2_en", wr_en2, 1'b0);
    chk("sm_err", err2, 1'b1);
    chk("sm_done", done2, 1'b0);
    chk("sm_ready", in_ready2, 1'b0);
    chk("sm_count", count2, 3'd4);

    // reset asserted while in EXIT2
    do_reset();
    drive(5'd18, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rx_exit1_en", wr_en, 1'b1);
    reset = 1'b1;
    #1;
    chk("rx_async_en", wr_en, 1'b0);
    chk("rx_async_count", count, 11'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rx_en", wr_en, 1'b0);
    chk("rx_flags", {full, err, done}, 3'b000);
    chk("rx_ready", in_ready, 1'b1);
    drive(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rx_add_addr", wr_addr, 10'd0);
    chk("rx_add_data", wr_data, 32'h00221820);
    chk("rx_add_count", count, 11'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
